// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between the link master and spi_slave_regs.
// SPI_SLAVE_MISO_OE_EN adds miso_oe for a shared, tri-stated MISO line.
interface spi_slave_regs_if;
    logic sclk;
    logic csn;
    logic mosi;
    logic miso;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic miso_oe;

    modport master (output sclk, csn, mosi, input miso, miso_oe);
    modport slave  (input sclk, csn, mosi, output miso, miso_oe);
`else
    modport master (output sclk, csn, mosi, input miso);
    modport slave  (input sclk, csn, mosi, output miso);
`endif
endinterface

// File: rtl/spi_slave_regs.sv
// Oversampling SPI responder with a local 8-bit register file and a host read port.
// Optional macro SPI_SLAVE_MISO_OE_EN adds a registered miso_oe output.
module spi_slave_regs #(
    parameter int         REG_NUM = 128,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_slave_regs_if.slave        spi,
    output logic                   wr_valid,
    output logic [6:0]             wr_addr,
    output logic [7:0]             wr_data,
    output logic                   rd_valid,
    output logic [6:0]             rd_addr,
    output logic                   frame_err,
    input  logic [6:0]             host_raddr,
    output logic [7:0]             host_rdata
);
    localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    logic [2:0] r_sclk_sync;
    logic [2:0] r_csn_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_live;
    logic       r_armed;
    state_t     r_state;
    logic [4:0] r_cnt;
    logic [7:0] r_cmd;
    logic [7:0] r_data;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_rd_byte;
    logic       r_miso;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_rd_valid;
    logic [6:0] r_rd_addr;
    logic       r_frame_err;
    logic [7:0] r_host_rdata;
    logic [7:0] r_regs [REG_NUM];

    logic w_sclk_rise, w_sclk_fall, w_csn_hi, w_csn_fall, w_csn_rise, w_mosi;

    assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
    assign w_csn_hi    =  r_csn_sync[1];
    assign w_csn_fall  = ~r_csn_sync[1] &  r_csn_sync[2];
    assign w_csn_rise  =  r_csn_sync[1] & ~r_csn_sync[2];
    assign w_mosi      =  r_mosi_sync[1];

    function automatic logic addr_impl(input logic [6:0] a);
        return int'({25'd0, a}) < REG_NUM;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync  <= 3'b111;
            r_csn_sync   <= 3'b111;
            r_mosi_sync  <= 2'b00;
            r_live       <= 2'b00;
            r_armed      <= 1'b0;
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_cmd        <= 8'h00;
            r_data       <= 8'h00;
            r_rw         <= 1'b0;
            r_addr       <= 7'h00;
            r_rd_byte    <= 8'h00;
            r_miso       <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= 7'h00;
            r_wr_data    <= 8'h00;
            r_rd_valid   <= 1'b0;
            r_rd_addr    <= 7'h00;
            r_frame_err  <= 1'b0;
            r_host_rdata <= 8'h00;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= RST_VAL;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi.sclk};
            r_csn_sync  <= {r_csn_sync[1:0], spi.csn};
            r_mosi_sync <= {r_mosi_sync[0], spi.mosi};
            r_wr_valid  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            // r_live masks the reset-value sync stages so a frame in flight at
            // reset release cannot arm the decoder before csn is seen high.
            r_live <= {r_live[0], 1'b1};
            if (r_live[1] && w_csn_hi) r_armed <= 1'b1;

            r_host_rdata <= addr_impl(host_raddr) ? r_regs[host_raddr[AW-1:0]] : 8'h00;

            if (w_csn_hi)                        r_cnt <= 5'd0;
            else if (w_sclk_rise && r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;

            case (r_state)
                S_IDLE: if (w_csn_fall && r_armed) r_state <= S_ADDR;
                S_ADDR: begin
                    if (w_sclk_rise) r_cmd <= {r_cmd[6:0], w_mosi};
                    if (r_cnt == 5'd8) begin
                        r_rw    <= r_cmd[7];
                        r_addr  <= r_cmd[6:0];
                        r_state <= S_DATA;
                        if (!r_cmd[7]) begin
                            r_rd_byte  <= addr_impl(r_cmd[6:0]) ? r_regs[r_cmd[AW-1:0]] : 8'h00;
                            r_rd_valid <= 1'b1;
                            r_rd_addr  <= r_cmd[6:0];
                        end
                    end
                end
                S_DATA: begin
                    if (w_sclk_rise) r_data <= {r_data[6:0], w_mosi};
                    if (r_cnt == 5'd16) begin
                        r_state <= S_DONE;
                        if (r_rw) begin
                            if (addr_impl(r_addr)) r_regs[r_addr[AW-1:0]] <= r_data;
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_addr;
                            r_wr_data  <= r_data;
                        end
                    end
                end
                default: ;
            endcase

            if (w_csn_rise && r_state != S_IDLE) begin
                r_state     <= S_IDLE;
                r_frame_err <= (r_cnt != 5'd16);
            end

            // Fall that opens bit k sees k rises counted; data bits are k = 8..15.
            if (w_csn_hi)
                r_miso <= 1'b0;
            else if (w_sclk_fall)
                r_miso <= (!r_rw && r_state == S_DATA && r_cnt[4:3] == 2'b01)
                          ? r_rd_byte[~r_cnt[2:0]] : 1'b0;
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    logic r_miso_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_miso_oe <= 1'b0;
        else        r_miso_oe <= !w_csn_hi && !r_rw && (r_state == S_DATA || r_state == S_DONE);
    end

    assign spi.miso_oe = r_miso_oe;
`endif

    assign spi.miso   = r_miso;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign rd_valid   = r_rd_valid;
    assign rd_addr    = r_rd_addr;
    assign frame_err  = r_frame_err;
    assign host_rdata = r_host_rdata;
endmodule
